// File: rtl/tt_pkg.sv
// Shared types and limits for the truth-table scanner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tt_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int N_IN_MIN   = 1;
    localparam int N_IN_MAX   = 6;
    localparam int SETTLE_MIN = 1;
    localparam int SETTLE_MAX = 65535;

    // Number of rows in the truth table of an n-input block.
    function automatic int tbl_w(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Down-counter measuring the dwell of one applied vector.
// Latency: term asserts combinationally in the cycle the count reaches zero while enabled.
// Backpressure: none; load has priority over enable.
//   clk, rst_n : clock, synchronous active-low reset
//   load/load_val : preset the count
//   en : count down this cycle
//   term : enabled and count is zero (last dwell cycle)
module tt_settle_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         term
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign term = en && (cnt == '0);

endmodule

// File: rtl/tt_scanner.sv
// Clocked exerciser: walks all 2**N_IN input vectors, samples s_in, builds truth table + minterm count.
// Latency: SETTLE+1 cycles per vector; done rises 2**N_IN*(SETTLE+1)+1 edges after start is taken.
// Backpressure: none; start is ignored while a scan is running.
//   clk, rst_n   : clock, synchronous active-low reset
//   start        : one-cycle scan request (accepted in IDLE or DONE)
//   s_in         : output of the exercised block
//   vec_out      : vector applied to the block (MSB = first input)
//   vec_valid    : vec_out is being applied
//   busy / done  : scan running / table_out complete
//   table_out    : bit k = sampled s_in for vector k
//   minterm_cnt  : number of ones in table_out
// Optional TT_SCANNER_CHECK_EN: exp_table input, mismatch / first_bad outputs.
module tt_scanner
    import tt_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 s_in,
    output logic [N_IN-1:0]      vec_out,
    output logic                 vec_valid,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   table_out,
`ifdef TT_SCANNER_CHECK_EN
    input  logic [2**N_IN-1:0]   exp_table,
    output logic                 mismatch,
    output logic [N_IN-1:0]      first_bad,
`endif
    output logic [N_IN:0]        minterm_cnt
);

    localparam int TW = tbl_w(N_IN);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    generate
        if (N_IN < N_IN_MIN || N_IN > N_IN_MAX) begin : g_bad_n_in
            $error("tt_scanner: N_IN out of range");
        end
        if (SETTLE < SETTLE_MIN || SETTLE > SETTLE_MAX) begin : g_bad_settle
            $error("tt_scanner: SETTLE out of range");
        end
    endgenerate

    state_t state;
    state_t state_nxt;

    logic   start_ok;
    logic   last_vec;
    logic   timer_load;
    logic   timer_term;

    assign start_ok = start && ((state == IDLE) || (state == DONE));
    assign last_vec = &vec_out;

    // The dwell is re-armed whenever a fresh vector goes on the bus.
    assign timer_load = start_ok || ((state == SAMPLE) && !last_vec);

    tt_settle_timer #(
        .W (CW)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (CW'(SETTLE - 1)),
        .en       (state == DRIVE),
        .term     (timer_term)
    );

    always_comb begin
        state_nxt = state;
        vec_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = DRIVE;
            end
            DRIVE: begin
                vec_valid = 1'b1;
                busy      = 1'b1;
                if (timer_term) state_nxt = SAMPLE;
            end
            SAMPLE: begin
                vec_valid = 1'b1;
                busy      = 1'b1;
                state_nxt = last_vec ? DONE : DRIVE;
            end
            DONE: begin
                if (start) state_nxt = DRIVE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // done is registered from the DONE state, so it rises one edge after the
    // last sample lands and drops on the edge that accepts a restart.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            vec_out     <= '0;
            done        <= 1'b0;
            table_out   <= '0;
            minterm_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (start_ok) begin
                vec_out     <= '0;
                done        <= 1'b0;
                table_out   <= '0;
                minterm_cnt <= '0;
            end else if (state == SAMPLE) begin
                table_out[vec_out] <= s_in;
                minterm_cnt        <= minterm_cnt + {{N_IN{1'b0}}, s_in};
                vec_out            <= last_vec ? '0 : vec_out + 1'b1;
            end else if (state == DONE) begin
                done <= 1'b1;
            end
        end
    end

`ifdef TT_SCANNER_CHECK_EN
    // Only the first disagreeing vector is latched; later ones are ignored.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mismatch  <= 1'b0;
            first_bad <= '0;
        end else if (start_ok) begin
            mismatch  <= 1'b0;
            first_bad <= '0;
        end else if ((state == SAMPLE) && !mismatch && (s_in != exp_table[vec_out])) begin
            mismatch  <= 1'b1;
            first_bad <= vec_out;
        end
    end
`endif

    logic unused_tw;
    assign unused_tw = (TW == 0);

endmodule

// File: tb/tb_tt_scanner.sv
module tb_tt_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic       rn [3];
    logic       st [3];
    logic       si [3];
    logic [7:0] fn [3];
    logic [7:0] ex [3];
    int         sett [3];

    logic [2:0] vo [3];
    logic       vv [3];
    logic       bz [3];
    logic       dn [3];
    logic [7:0] tb [3];
    logic [3:0] mc [3];
    logic       mm [3];
    logic [2:0] fb [3];

    logic [1:0] vo0, vo1;
    logic [2:0] vo2;
    logic [3:0] tb0, tb1;
    logic [7:0] tb2;
    logic [2:0] mc0, mc1;
    logic [3:0] mc2;
    logic       vv0, vv1, vv2, bz0, bz1, bz2, dn0, dn1, dn2;
    logic [3:0] ex0, ex1;
    logic [7:0] ex2;
    assign ex0 = ex[0][3:0];
    assign ex1 = ex[1][3:0];
    assign ex2 = ex[2];

`ifdef TT_SCANNER_CHECK_EN
    logic       mm0, mm1, mm2;
    logic [1:0] fb0, fb1;
    logic [2:0] fb2;
    assign mm[0] = mm0;
    assign mm[1] = mm1;
    assign mm[2] = mm2;
    assign fb[0] = {1'b0, fb0};
    assign fb[1] = {1'b0, fb1};
    assign fb[2] = fb2;
`endif

    tt_scanner #(.N_IN(2), .SETTLE(1)) u0 (
        .clk(clk), .rst_n(rn[0]), .start(st[0]), .s_in(si[0]),
        .vec_out(vo0), .vec_valid(vv0), .busy(bz0), .done(dn0), .table_out(tb0),
`ifdef TT_SCANNER_CHECK_EN
        .exp_table(ex0), .mismatch(mm0), .first_bad(fb0),
`endif
        .minterm_cnt(mc0)
    );

    tt_scanner #(.N_IN(2), .SETTLE(3)) u1 (
        .clk(clk), .rst_n(rn[1]), .start(st[1]), .s_in(si[1]),
        .vec_out(vo1), .vec_valid(vv1), .busy(bz1), .done(dn1), .table_out(tb1),
`ifdef TT_SCANNER_CHECK_EN
        .exp_table(ex1), .mismatch(mm1), .first_bad(fb1),
`endif
        .minterm_cnt(mc1)
    );

    tt_scanner #(.N_IN(3), .SETTLE(1)) u2 (
        .clk(clk), .rst_n(rn[2]), .start(st[2]), .s_in(si[2]),
        .vec_out(vo2), .vec_valid(vv2), .busy(bz2), .done(dn2), .table_out(tb2),
`ifdef TT_SCANNER_CHECK_EN
        .exp_table(ex2), .mismatch(mm2), .first_bad(fb2),
`endif
        .minterm_cnt(mc2)
    );

    assign vo[0] = {1'b0, vo0};
    assign vo[1] = {1'b0, vo1};
    assign vo[2] = vo2;
    assign vv[0] = vv0;
    assign vv[1] = vv1;
    assign vv[2] = vv2;
    assign bz[0] = bz0;
    assign bz[1] = bz1;
    assign bz[2] = bz2;
    assign dn[0] = dn0;
    assign dn[1] = dn1;
    assign dn[2] = dn2;
    assign tb[0] = {4'b0, tb0};
    assign tb[1] = {4'b0, tb1};
    assign tb[2] = tb2;
    assign mc[0] = {1'b0, mc0};
    assign mc[1] = {1'b0, mc1};
    assign mc[2] = mc2;

    // Exercised blocks: each is a lookup of fn[i]. While a vector has been on
    // the bus for fewer than SETTLE cycles its output is random garbage, so
    // only a correctly timed sample sees the true function value.
    int         age [3];
    logic [2:0] prev_vo [3];
    logic       prev_vv [3];
    initial begin
        for (int i = 0; i < 3; i++) begin
            age[i] = 0; prev_vo[i] = '0; prev_vv[i] = 1'b0; si[i] = 1'b0;
        end
    end
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (vv[i] && prev_vv[i] && (vo[i] == prev_vo[i])) age[i] = age[i] + 1;
            else age[i] = 0;
            prev_vv[i] = vv[i];
            prev_vo[i] = vo[i];
            si[i] = (age[i] >= sett[i]) ? fn[i][vo[i]] : (($urandom & 1) != 0);
        end
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic int popcnt(input logic [7:0] v);
        int n = 0;
        for (int k = 0; k < 8; k++) n += v[k] ? 1 : 0;
        return n;
    endfunction

    task automatic check_zero(input int i, input string why);
        check($sformatf("%s u%0d vec_out", why, i), vo[i], 0);
        check($sformatf("%s u%0d vec_valid", why, i), vv[i], 0);
        check($sformatf("%s u%0d busy", why, i), bz[i], 0);
        check($sformatf("%s u%0d done", why, i), dn[i], 0);
        check($sformatf("%s u%0d table", why, i), tb[i], 0);
        check($sformatf("%s u%0d cnt", why, i), mc[i], 0);
    endtask

    // One scan on instance i with block function func. Expectations follow
    // from the timing rules: cycle c after the accepting edge shows vector
    // c/(SETTLE+1), and c/(SETTLE+1) vectors have been recorded so far.
    task automatic run_scan(input int i, input logic [7:0] func,
                            input int start_at, input int rst_at);
        int   n, per, nv, t, smp, fb_e;
        logic [7:0] mask, exp_tab;
        logic mm_e;
        n   = (i == 2) ? 3 : 2;
        per = sett[i] + 1;
        nv  = 1 << n;
        t   = nv * per + 1;
        fn[i] = func;
        @(posedge clk); #1 st[i] = 1'b1;
        @(posedge clk); #1 st[i] = 1'b0;
        for (int c = 0; c <= t; c++) begin
            @(negedge clk);
            if (c == rst_at) begin
                rn[i] = 1'b0;
                st[i] = 1'b1;
                @(negedge clk);
                check_zero(i, "midreset");
                rn[i] = 1'b1;
                st[i] = 1'b0;
                return;
            end
            smp     = (c / per < nv) ? c / per : nv;
            mask    = (smp >= 8) ? 8'hFF : 8'((1 << smp) - 1);
            exp_tab = func & mask;
            check($sformatf("u%0d c%0d vec_valid", i, c), vv[i], (c < nv * per) ? 1 : 0);
            check($sformatf("u%0d c%0d busy", i, c), bz[i], (c < nv * per) ? 1 : 0);
            check($sformatf("u%0d c%0d vec_out", i, c), vo[i], (c < nv * per) ? c / per : 0);
            check($sformatf("u%0d c%0d done", i, c), dn[i], (c == t) ? 1 : 0);
            check($sformatf("u%0d c%0d table", i, c), tb[i], exp_tab);
            check($sformatf("u%0d c%0d cnt", i, c), mc[i], popcnt(exp_tab));
`ifdef TT_SCANNER_CHECK_EN
            if (c == 0) check($sformatf("u%0d mismatch cleared", i), mm[i], 0);
`endif
            st[i] = (c == start_at) ? 1'b1 : 1'b0;
        end
        @(negedge clk);
        check($sformatf("u%0d done hold", i), dn[i], 1);
        check($sformatf("u%0d table hold", i), tb[i], func & ((nv >= 8) ? 8'hFF : 8'((1 << nv) - 1)));
`ifdef TT_SCANNER_CHECK_EN
        mm_e = 1'b0;
        fb_e = 0;
        for (int k = 0; k < nv; k++) begin
            if (!mm_e && (func[k] != ex[i][k])) begin
                mm_e = 1'b1;
                fb_e = k;
            end
        end
        check($sformatf("u%0d mismatch", i), mm[i], mm_e);
        check($sformatf("u%0d first_bad", i), fb[i], fb_e);
`endif
    endtask

    initial begin
        sett[0] = 1; sett[1] = 3; sett[2] = 1;
        ex[0] = 8'h02; ex[1] = 8'h08; ex[2] = 8'hE8;
        for (int i = 0; i < 3; i++) begin
            rn[i] = 1'b0; st[i] = 1'b0; fn[i] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) check_zero(i, "reset");
        for (int i = 0; i < 3; i++) rn[i] = 1'b1;

        run_scan(0, 8'h02, -1, -1);            // ~x & y
        run_scan(1, 8'h08, -1, -1);            // x & y, long dwell
        run_scan(0, 8'h06, 4, -1);             // xor, start during DRIVE of vector 2
        run_scan(0, 8'(($urandom & 8'h0F) | 8'h01), -1, 3);  // reset in SAMPLE of vector 1
        run_scan(0, 8'h0A, -1, -1);            // s = y after the abort
        run_scan(2, 8'hE8, -1, -1);            // majority of three
        run_scan(2, 8'($urandom), -1, -1);     // restart straight from DONE
        for (int k = 0; k < 6; k++) begin
            int i;
            i = $urandom_range(2, 0);
            run_scan(i, (i == 2) ? 8'($urandom) : 8'($urandom & 8'h0F), -1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tt_scanner.md
Name: tt_scanner

Overview:
- Sequential exerciser for small combinational blocks with N_IN inputs and 1 output.
- Drives every input vector in ascending binary order, waits a settle time, samples the block's output, and assembles the full truth table plus a minterm count.
- Sits between a combinational unit under test and the lab bench or top-level checker.
- Replaces hand-written stimulus sequences with a reusable clocked engine.

Parameters:
- N_IN, 2: number of inputs of the exercised block (1..6).
- SETTLE, 1: cycles each vector is held before sampling (>=1; 0 is illegal, flag via elaboration check).

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  one-cycle pulse requesting a scan.
- s_in  input  1  output of the exercised block.
- vec_out  output  N_IN  drives the exercised block's inputs; MSB = first input (x), LSB = last (y).
- vec_valid  output  1  high while vec_out is being applied.
- busy  output  1  scan in progress.
- done  output  1  scan complete, table_out valid.
- table_out  output  2**N_IN  bit k = sampled s_in for vector k.
- minterm_cnt  output  N_IN+1  number of ones in table_out.

Behaviour:
- Reset is synchronous and active-low. On a clock edge with rst_n=0:
  - state=IDLE.
  - vec_out=0, vec_valid=0, busy=0, done=0, table_out=0, minterm_cnt=0, settle counter=0.
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- IDLE:
  - start=1 -> DRIVE with vec_out=0, settle count=0, table_out and minterm_cnt cleared.
- DRIVE:
  - vec_valid=1, busy=1.
  - Settle counter increments each cycle.
  - When count==SETTLE-1 -> SAMPLE, so DRIVE lasts exactly SETTLE cycles.
- SAMPLE:
  - vec_valid=1, busy=1.
  - At this state's closing edge: table_out[vec_out] <= s_in, and minterm_cnt increments if s_in=1.
  - If vec_out == 2**N_IN-1 -> DONE.
  - Otherwise -> DRIVE with vec_out+1 and settle count=0.
- DONE:
  - done=1, busy=0, vec_valid=0, vec_out=0.
  - table_out and minterm_cnt hold.
  - start=1 -> restart exactly as from IDLE: done drops next cycle and the table is cleared.
- Timing:
  - Each vector takes SETTLE+1 cycles.
  - done rises 2**N_IN*(SETTLE+1)+1 edges after the edge that sampled start.
  - With N_IN=2, SETTLE=1 this is 9 edges.
- Boundaries:
  - start while busy: ignored.
  - The vector counter never wraps; the terminal vector always exits to DONE.
  - rst_n low mid-scan: abort to IDLE with the full reset values, even if start is high in the same cycle.
  - s_in is sampled only in SAMPLE; changes on s_in in DRIVE are don't-care.
  - table_out reads 0 for vectors not yet sampled during a scan.

Optional Feature:
- Macro TT_SCANNER_CHECK_EN.
- When defined:
  - Adds input exp_table [2**N_IN] and outputs mismatch (1) and first_bad (N_IN).
  - In each SAMPLE, if s_in != exp_table[vec_out] and mismatch=0: set mismatch=1 and first_bad=vec_out.
  - Both are cleared by reset or by an accepted start, and hold through DONE.
- When not defined: these ports do not exist and there is no compare logic.

Decomposition:
- Package tt_pkg:
  - state enum (IDLE, DRIVE, SAMPLE, DONE).
  - localparam function tbl_w(n) = 2**n.
  - Legal ranges for N_IN and SETTLE.
- One sub-module, tt_settle_timer:
  - Parameterised down-counter with load, enable and a terminal pulse.
  - Instantiated once for the DRIVE dwell.
- Everything else stays in tt_scanner.

Test Plan:
- Setup: N_IN=2, SETTLE=1; exercised block s = ~x & y.
  - Pulse start -> vec_out sequence 00,01,10,11, each valid 2 cycles.
  - done at edge 9, table_out=4'b0010, minterm_cnt=1.
- Same setup with AND2, SETTLE=3:
  - -> table_out=4'b1000, minterm_cnt=1, done at edge 17.
- XOR2 scan, then start pulsed during DRIVE of vector 2:
  - -> start ignored, table_out=4'b0110, minterm_cnt=2.
- rst_n=0 for 1 cycle during SAMPLE of vector 1:
  - -> next cycle state IDLE, all outputs 0.
  - A new start then gives the full correct table.
- N_IN=3 with majority function, then restart from DONE:
  - -> table_out=8'b11101000, minterm_cnt=4.
  - done drops the cycle after start and the table is cleared before resampling.
- TT_SCANNER_CHECK_EN, exp_table=4'b0010, block s = y:
  - -> table_out=4'b1010, mismatch=1, first_bad=2'b11.
